riscv_branch_predictor: RTL
===========================

Name: riscv_branch_predictor

Overview:
- Fetch-side counterpart of the execute-stage branch resolver. Predicts direction and target for the fetch PC, then learns from resolved outcomes that execute sends back.
- Direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- Also keeps branch and mispredict statistics counters for performance monitoring.

Parameters:
- ENTRIES, 64, number of BTB entries; power of two, at least 2.
- INDEX_BITS, $clog2(ENTRIES), index width; derived, do not override.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- lookup_valid  in  1  a fetch lookup is requested this cycle.
- lookup_pc  in  32  fetch PC.
- pred_hit  out  1  BTB entry is valid and its tag matches.
- pred_taken  out  1  predicted taken.
- pred_target  out  32  predicted next PC.
- upd_valid  in  1  a resolved branch is presented this cycle.
- upd_pc  in  32  PC of the resolved branch.
- upd_taken  in  1  resolved direction.
- upd_target  in  32  resolved target (pc+imm).
- upd_mispredict  in  1  execute detected a mispredict; used for statistics only.
- flush  in  1  synchronous invalidate of all BTB entries.
- stat_branches  out  32  count of upd_valid cycles.
- stat_mispredicts  out  32  count of upd_valid & upd_mispredict cycles.

Behaviour:
- Address split:
  - index = pc[INDEX_BITS+1:2]
  - tag = pc[31:INDEX_BITS+2]
  - pc[1:0] is ignored.
- Per-entry state: valid (1 bit), tag, target (32 bits), ctr (2 bits).
- Reset (asynchronous): all valid=0, all ctr=2'b01, stat counters=0. Tag and target need no reset.
- Lookup is combinational, with zero-cycle latency from lookup_pc to the outputs:
  - pred_hit = lookup_valid & valid[idx] & (tag[idx]==lookup tag)
  - pred_taken = pred_hit & ctr[idx][1]
  - pred_target = pred_taken ? target[idx] : lookup_pc+4; the addition wraps modulo 2^32.
  - When lookup_valid=0: pred_hit=0, pred_taken=0, pred_target=lookup_pc+4. This also holds during and immediately after reset.
- Update is applied at the rising edge when upd_valid=1:
  - Hit (valid and tag match), taken: ctr saturating increment (max 2'b11); target <= upd_target.
  - Hit, not taken: ctr saturating decrement (min 2'b00); target unchanged.
  - Miss, taken: allocate the entry, overwriting any alias. Set valid=1, tag, target=upd_target, ctr=2'b10.
  - Miss, not taken: no change.
- Counter encoding: 00 = strongly not-taken, 01 = weakly not-taken, 10 = weakly taken, 11 = strongly taken.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents (no bypass). The new state is visible the next cycle.
- flush=1: all valid <= 0 at the edge. flush has priority over a simultaneous update; that update is dropped from the BTB.
- Statistics:
  - Statistics update even when flush=1.
  - Both counters wrap from 0xFFFFFFFF to 0.
  - flush does not clear them; only rst_n does.
- Reset asserted mid-operation: all state returns to reset values immediately. No partial update may survive.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN=32
  - counter encodings CTR_SNT/CTR_WNT/CTR_WT/CTR_ST
  - CTR_ALLOC=CTR_WT and CTR_RESET=CTR_WNT
- One natural sub-module, riscv_sat_counter2: a combinational next-state function (ctr, taken) -> ctr_next, instanced once on the update path.
- BTB arrays are plain register vectors inside riscv_branch_predictor, with no SRAM macro.

Test Plan:
- Reset, then lookup 0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104; both stat counters 0.
- Update pc=0x100 taken, target=0x80; next cycle lookup 0x100 -> hit=1, taken=1, target=0x80 (ctr=10). A same-cycle lookup during the update cycle -> miss, target 0x104.
- Training sequence at 0x100:
  - From ctr=10, two not-taken updates -> ctr 01 then 00; lookup gives hit=1, taken=0, target=0x104.
  - A third not-taken update stays at 00.
  - Then three taken updates -> ctr 11, and a fourth taken update stays at 11.
- Aliasing with ENTRIES=64:
  - Allocate 0x100 taken -> 0x80, then lookup 0x200 -> miss (same index, different tag).
  - Update 0x200 taken -> 0x40; lookup 0x100 now misses and 0x200 hits with target 0x40.
- Flush with simultaneous taken update at 0x300 -> all lookups miss next cycle, including 0x300; stat_branches still increments.
- Statistics and reset:
  - Issue 5 updates, 2 with upd_mispredict=1 -> stat_branches=5, stat_mispredicts=2.
  - Assert rst_n=0 mid-sequence -> counters 0 and all lookups miss immediately, without waiting for a clock edge.
  - Force stat_branches to 0xFFFFFFFF, then issue one update -> stat_branches reads 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end constants: datapath width and 2-bit branch counter encodings.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam logic [1:0] CTR_ALLOC = CTR_WT;
  localparam logic [1:0] CTR_RESET = CTR_WNT;

endpackage

// File: rtl/riscv_sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter.
module riscv_sat_counter2
  import riscv_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/riscv_branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, combinational lookup and
// edge-triggered training from resolved branches, plus branch/mispredict statistics.
module riscv_branch_predictor
  import riscv_pkg::*;
#(
  parameter int unsigned ENTRIES    = 64,
  parameter int unsigned INDEX_BITS = $clog2(ENTRIES)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lookup_valid,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_mispredict,
  input  logic            flush,
  output logic [XLEN-1:0] stat_branches,
  output logic [XLEN-1:0] stat_mispredicts
);

  localparam int unsigned TAG_BITS = XLEN - INDEX_BITS - 2;

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  logic [XLEN-1:0] stat_branches_q;
  logic [XLEN-1:0] stat_mispredicts_q;

  logic [INDEX_BITS-1:0] lk_idx;
  logic [TAG_BITS-1:0]   lk_tag;
  logic [INDEX_BITS-1:0] upd_idx;
  logic [TAG_BITS-1:0]   upd_tag;
  logic                  upd_hit;
  logic [1:0]            ctr_next;
  logic                  unused_pc_bits;

  assign lk_idx  = lookup_pc[INDEX_BITS+1:2];
  assign lk_tag  = lookup_pc[XLEN-1:INDEX_BITS+2];
  assign upd_idx = upd_pc[INDEX_BITS+1:2];
  assign upd_tag = upd_pc[XLEN-1:INDEX_BITS+2];
  assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  // Lookup reads pre-update state; there is deliberately no bypass from the update port.
  always_comb begin
    pred_hit    = lookup_valid & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
    pred_taken  = pred_hit & ctr_q[lk_idx][1];
    pred_target = pred_taken ? target_q[lk_idx] : lookup_pc + 32'd4;
  end

  assign upd_hit = valid_q[upd_idx] & (tag_q[upd_idx] == upd_tag);

  riscv_sat_counter2 u_sat_counter2 (
    .ctr      (ctr_q[upd_idx]),
    .taken    (upd_taken),
    .ctr_next (ctr_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_RESET;
    end else if (flush) begin
      valid_q <= '0;
    end else if (upd_valid) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= ctr_next;
      end else if (upd_taken) begin
        valid_q[upd_idx] <= 1'b1;
        ctr_q[upd_idx]   <= CTR_ALLOC;
      end
    end
  end

  // Tag and target carry no reset; they only matter once valid is set.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && upd_valid && upd_taken) begin
      target_q[upd_idx] <= upd_target;
      if (!upd_hit) tag_q[upd_idx] <= upd_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else if (upd_valid) begin
      stat_branches_q <= stat_branches_q + 32'd1;
      if (upd_mispredict) stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;

endmodule
